// File: rtl/afu_wr_buffer_if.sv
// Bundle of the user-side write request, CCI TX write channel and write-response signals.
// slave: the write buffer itself; master: the AFU user logic / CCI environment around it.
interface afu_wr_buffer_if #(
  parameter int unsigned ADDR_LMT    = 20,
  parameter int unsigned MDATA       = 14,
  parameter int unsigned CACHE_WIDTH = 512
);
  logic                   usr_wr_en;
  logic [ADDR_LMT-1:0]    usr_wr_addr;
  logic [MDATA-1:0]       usr_wr_mdata;
  logic [CACHE_WIDTH-1:0] usr_wr_data;
  logic                   usr_wr_almostfull;
  logic                   tx_wr_en;
  logic [ADDR_LMT-1:0]    tx_wr_addr;
  logic [MDATA-1:0]       tx_wr_mdata;
  logic [CACHE_WIDTH-1:0] tx_wr_data;
  logic                   tx_wr_almostfull;
  logic                   wr_rsp0_valid;
  logic                   wr_rsp1_valid;

  modport slave (
    input  usr_wr_en, usr_wr_addr, usr_wr_mdata, usr_wr_data,
    input  tx_wr_almostfull, wr_rsp0_valid, wr_rsp1_valid,
    output usr_wr_almostfull, tx_wr_en, tx_wr_addr, tx_wr_mdata, tx_wr_data
  );

  modport master (
    output usr_wr_en, usr_wr_addr, usr_wr_mdata, usr_wr_data,
    output tx_wr_almostfull, wr_rsp0_valid, wr_rsp1_valid,
    input  usr_wr_almostfull, tx_wr_en, tx_wr_addr, tx_wr_mdata, tx_wr_data
  );
endinterface

// File: rtl/afu_wr_buffer.sv
// Write buffer between the AFU user FSM and the CCI TX write channel; tracks outstanding writes.
// Optional: define AFU_WRBUF_STATS_EN to add stat_issued/stat_done counters.
module afu_wr_buffer #(
  parameter int unsigned ADDR_LMT    = 20,
  parameter int unsigned MDATA       = 14,
  parameter int unsigned CACHE_WIDTH = 512,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned AF_THRESH   = 2,
  parameter int unsigned MAX_OUTST   = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  afu_wr_buffer_if.slave wr,
  output logic [7:0]  outstanding,
  output logic        idle,
  output logic [1:0]  err
`ifdef AFU_WRBUF_STATS_EN
  ,
  output logic [31:0] stat_issued,
  output logic [31:0] stat_done
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = ADDR_LMT + MDATA + CACHE_WIDTH;
  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_P    = (AW+1)'(AF_THRESH);
  localparam logic [7:0]  MAX_P   = 8'(MAX_OUTST);

  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, count, free_cnt;
  logic          empty, full, do_pop, do_push;
  logic [9:0]    outst_inc, outst_dec;

  always_comb begin
    count     = wr_ptr - rd_ptr;
    free_cnt  = DEPTH_P - count;
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop    = !empty && !wr.tx_wr_almostfull && (outstanding < MAX_P);
    // A pop in the same cycle frees the head slot, so a push into a full FIFO is still accepted
    do_push   = wr.usr_wr_en && (!full || do_pop);
    outst_inc = {2'b00, outstanding} + {9'd0, do_pop};
    outst_dec = {9'd0, wr.wr_rsp0_valid} + {9'd0, wr.wr_rsp1_valid};
    wr.usr_wr_almostfull = (free_cnt <= AF_P);
    idle      = empty && (outstanding == 8'd0) && !wr.tx_wr_en;
  end

  // Storage is not reset; validity is tracked entirely by the pointers
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr[AW-1:0]] <= {wr.usr_wr_addr, wr.usr_wr_mdata, wr.usr_wr_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      wr.tx_wr_en   <= 1'b0;
      wr.tx_wr_addr <= '0;
      wr.tx_wr_mdata <= '0;
      wr.tx_wr_data <= '0;
      outstanding   <= '0;
      err           <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        {wr.tx_wr_addr, wr.tx_wr_mdata, wr.tx_wr_data} <= mem[rd_ptr[AW-1:0]];
      end
      wr.tx_wr_en <= do_pop;
      if (wr.usr_wr_en && full && !do_pop)
        err[0] <= 1'b1;
      if (outst_inc < outst_dec) begin
        outstanding <= '0;
        err[1]      <= 1'b1;
      end else begin
        outstanding <= 8'(outst_inc - outst_dec);
      end
    end
  end

`ifdef AFU_WRBUF_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_issued <= '0;
      stat_done   <= '0;
    end else begin
      stat_issued <= stat_issued + {31'd0, do_pop};
      stat_done   <= stat_done + {31'd0, wr.wr_rsp0_valid} + {31'd0, wr.wr_rsp1_valid};
    end
  end
`endif

endmodule

// File: tb/tb_afu_wr_buffer.sv
// Directed, table-driven bench for afu_wr_buffer plus multi-cycle corner-case sequences.
module tb_afu_wr_buffer;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  afu_wr_buffer_if #(.ADDR_LMT(20), .MDATA(14), .CACHE_WIDTH(512)) bus ();
  afu_wr_buffer_if #(.ADDR_LMT(20), .MDATA(14), .CACHE_WIDTH(512)) bif ();

  logic [7:0] outst, outst4;
  logic       idle, idle4;
  logic [1:0] err, err4;
`ifdef AFU_WRBUF_STATS_EN
  logic [31:0] st_iss, st_done, st_iss4, st_done4;
`endif

  afu_wr_buffer dut (
    .clk(clk), .reset_n(reset_n), .wr(bus.slave),
    .outstanding(outst), .idle(idle), .err(err)
`ifdef AFU_WRBUF_STATS_EN
    , .stat_issued(st_iss), .stat_done(st_done)
`endif
  );

  afu_wr_buffer #(.MAX_OUTST(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .wr(bif.slave),
    .outstanding(outst4), .idle(idle4), .err(err4)
`ifdef AFU_WRBUF_STATS_EN
    , .stat_issued(st_iss4), .stat_done(st_done4)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic push, input logic [19:0] a, input logic [13:0] m,
                       input logic [31:0] d, input logic taf, input logic r0, input logic r1);
    bus.usr_wr_en        = push;
    bus.usr_wr_addr      = a;
    bus.usr_wr_mdata     = m;
    bus.usr_wr_data      = {480'd0, d};
    bus.tx_wr_almostfull = taf;
    bus.wr_rsp0_valid    = r0;
    bus.wr_rsp1_valid    = r1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        push;
    logic [19:0] addr;
    logic [13:0] mdata;
    logic [31:0] data;
    logic        taf, r0, r1;
    logic        e_en;
    logic [19:0] e_addr;
    logic [13:0] e_mdata;
    logic [31:0] e_data;
    logic [7:0]  e_out;
    logic        e_idle;
    logic [1:0]  e_err;
    logic        e_uaf;
  } vec_t;

  vec_t vec [14];
  int   n_iss;

  initial begin
    // single write, dual response, issue+response, response underflow
    vec[0]  = '{1, 20'h005, 14'h011, 32'h03, 0,0,0, 0, 20'h000, 14'h000, 32'h00, 8'd0, 0, 2'b00, 0};
    vec[1]  = '{0, 20'h000, 14'h000, 32'h00, 0,0,0, 1, 20'h005, 14'h011, 32'h03, 8'd1, 0, 2'b00, 0};
    vec[2]  = '{0, 20'h000, 14'h000, 32'h00, 0,0,0, 0, 20'h005, 14'h011, 32'h03, 8'd1, 0, 2'b00, 0};
    vec[3]  = '{0, 20'h000, 14'h000, 32'h00, 0,1,0, 0, 20'h005, 14'h011, 32'h03, 8'd0, 1, 2'b00, 0};
    vec[4]  = '{1, 20'h010, 14'h022, 32'hAA, 0,0,0, 0, 20'h005, 14'h011, 32'h03, 8'd0, 0, 2'b00, 0};
    vec[5]  = '{1, 20'h011, 14'h033, 32'hBB, 0,0,0, 1, 20'h010, 14'h022, 32'hAA, 8'd1, 0, 2'b00, 0};
    vec[6]  = '{0, 20'h000, 14'h000, 32'h00, 0,0,0, 1, 20'h011, 14'h033, 32'hBB, 8'd2, 0, 2'b00, 0};
    vec[7]  = '{0, 20'h000, 14'h000, 32'h00, 0,1,1, 0, 20'h011, 14'h033, 32'hBB, 8'd0, 1, 2'b00, 0};
    vec[8]  = '{1, 20'h020, 14'h044, 32'hCC, 0,0,0, 0, 20'h011, 14'h033, 32'hBB, 8'd0, 0, 2'b00, 0};
    vec[9]  = '{0, 20'h000, 14'h000, 32'h00, 0,0,0, 1, 20'h020, 14'h044, 32'hCC, 8'd1, 0, 2'b00, 0};
    vec[10] = '{1, 20'h021, 14'h055, 32'hDD, 0,0,0, 0, 20'h020, 14'h044, 32'hCC, 8'd1, 0, 2'b00, 0};
    vec[11] = '{0, 20'h000, 14'h000, 32'h00, 0,1,0, 1, 20'h021, 14'h055, 32'hDD, 8'd1, 0, 2'b00, 0};
    vec[12] = '{0, 20'h000, 14'h000, 32'h00, 0,1,0, 0, 20'h021, 14'h055, 32'hDD, 8'd0, 1, 2'b00, 0};
    vec[13] = '{0, 20'h000, 14'h000, 32'h00, 0,1,0, 0, 20'h021, 14'h055, 32'hDD, 8'd0, 1, 2'b10, 0};

    reset_n = 1'b0;
    drive(0, '0, '0, '0, 0, 0, 0);
    bif.usr_wr_en = 0; bif.usr_wr_addr = '0; bif.usr_wr_mdata = '0; bif.usr_wr_data = '0;
    bif.tx_wr_almostfull = 0; bif.wr_rsp0_valid = 0; bif.wr_rsp1_valid = 0;
    tick(); tick();

    chk("rst_tx_en",   bus.tx_wr_en, 0);
    chk("rst_tx_addr", bus.tx_wr_addr, 0);
    chk("rst_tx_data", bus.tx_wr_data, 0);
    chk("rst_outst",   outst, 0);
    chk("rst_idle",    idle, 1);
    chk("rst_err",     err, 0);
    chk("rst_uaf",     bus.usr_wr_almostfull, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(vec[i].push, vec[i].addr, vec[i].mdata, vec[i].data, vec[i].taf, vec[i].r0, vec[i].r1);
      tick();
      chk($sformatf("v%0d_en", i),    bus.tx_wr_en, vec[i].e_en);
      chk($sformatf("v%0d_addr", i),  bus.tx_wr_addr, vec[i].e_addr);
      chk($sformatf("v%0d_mdata", i), bus.tx_wr_mdata, vec[i].e_mdata);
      chk($sformatf("v%0d_data", i),  bus.tx_wr_data, {480'd0, vec[i].e_data});
      chk($sformatf("v%0d_outst", i), outst, vec[i].e_out);
      chk($sformatf("v%0d_idle", i),  idle, vec[i].e_idle);
      chk($sformatf("v%0d_err", i),   err, vec[i].e_err);
      chk($sformatf("v%0d_uaf", i),   bus.usr_wr_almostfull, vec[i].e_uaf);
    end

    // fill under CCI back-pressure, overflow, then drain in order
    for (int k = 0; k < 8; k++) begin
      drive(1, 20'h40 + 20'(k), 14'(k), 32'(k), 1, 0, 0);
      tick();
      chk($sformatf("fill%0d_uaf", k), bus.usr_wr_almostfull, (k + 1 >= 6));
      chk($sformatf("fill%0d_en", k), bus.tx_wr_en, 0);
    end
    drive(1, 20'h99, 14'h99, 32'h99, 1, 0, 0);
    tick();
    chk("ovf_err", err, 2'b11);
    chk("ovf_uaf", bus.usr_wr_almostfull, 1);
    drive(0, '0, '0, '0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("drain%0d_en", k), bus.tx_wr_en, 1);
      chk($sformatf("drain%0d_addr", k), bus.tx_wr_addr, 20'h40 + 20'(k));
      chk($sformatf("drain%0d_mdata", k), bus.tx_wr_mdata, 14'(k));
    end
    tick();
    chk("drain_end_en", bus.tx_wr_en, 0);
    chk("drain_outst", outst, 8);
    drive(0, '0, '0, '0, 0, 1, 1);
    for (int k = 0; k < 4; k++) tick();
    drive(0, '0, '0, '0, 0, 0, 0);
    chk("drain_rsp_outst", outst, 0);
    chk("drain_rsp_idle", idle, 1);

    // outstanding limit on the MAX_OUTST=4 instance
    n_iss = 0;
    for (int k = 0; k < 12; k++) begin
      bif.usr_wr_en   = (k < 6);
      bif.usr_wr_addr = 20'h60 + 20'(k);
      tick();
      if (bif.tx_wr_en) n_iss++;
    end
    bif.usr_wr_en = 0;
    chk("lim_issues", 32'(n_iss), 4);
    chk("lim_outst", outst4, 4);
    chk("lim_idle", idle4, 0);
    bif.wr_rsp1_valid = 1;
    tick();
    bif.wr_rsp1_valid = 0;
    chk("lim_rsp_en", bif.tx_wr_en, 0);
    chk("lim_rsp_outst", outst4, 3);
    tick();
    chk("lim_5th_en", bif.tx_wr_en, 1);
    chk("lim_5th_addr", bif.tx_wr_addr, 20'h64);
    chk("lim_5th_outst", outst4, 4);

    // asynchronous reset in the middle of a drain
    for (int k = 0; k < 4; k++) begin
      drive(1, 20'h70 + 20'(k), '0, '0, 1, 0, 0);
      tick();
    end
    drive(0, '0, '0, '0, 0, 0, 0);
    tick();
    chk("pre_rst_en", bus.tx_wr_en, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_en", bus.tx_wr_en, 0);
    chk("arst_idle", idle, 1);
    chk("arst_outst", outst, 0);
    chk("arst_err", err, 0);
`ifdef AFU_WRBUF_STATS_EN
    chk("arst_st_iss", st_iss, 0);
    chk("arst_st_done", st_done, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    tick(); tick();
    chk("post_rst_en", bus.tx_wr_en, 0);
    chk("post_rst_idle", idle, 1);

    drive(1, 20'h80, '0, '0, 0, 0, 0);
    tick();
    drive(1, 20'h81, '0, '0, 0, 0, 0);
    tick();
    drive(0, '0, '0, '0, 0, 0, 0);
    tick();
    chk("post_rst_outst", outst, 2);
    chk("post_rst_addr", bus.tx_wr_addr, 20'h81);
    drive(0, '0, '0, '0, 0, 1, 1);
    tick();
    drive(0, '0, '0, '0, 0, 0, 0);
    chk("dual_outst", outst, 0);
`ifdef AFU_WRBUF_STATS_EN
    chk("st_issued", st_iss, 2);
    chk("st_done", st_done, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
